output_serializer: RTL and testbench
====================================

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 SHALL have parameter IN_W, default 64: width of each filter output lane.
REQ-002 SHALL have parameter OUT_W, default 32: width of each serialized output sample.
REQ-003 SHALL have parameter SHIFT, default 31: right-shift applied at requantization, range 1..IN_W-1.
REQ-004 SHALL have parameter DEPTH, default 4: FIFO depth in 3-sample frames, power of two, at least 2.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports y_out, y_out1, y_out2, input, IN_W signed each: lanes 0/1/2 of one filter frame; lane 0 is the oldest sample.
REQ-008 SHALL have port in_valid, input, 1: frame on y_out* is valid.
REQ-009 SHALL have port in_ready, output, 1: block can accept a frame.
REQ-010 SHALL have port out_data, output, OUT_W signed: serialized requantized sample.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-013 SHALL have port sat_flag, output, 1: sticky saturation indicator.

Function
REQ-014 SHALL accept a frame on a rising edge where in_valid and in_ready are both 1; in_ready SHALL equal not-full, with no same-cycle bypass when full.
REQ-015 SHALL requantize each lane before the FIFO write: add 2^(SHIFT-1), then arithmetic shift right by SHIFT in IN_W+1-bit arithmetic.
REQ-016 SHALL store the three requantized lanes as one FIFO entry.
REQ-017 SHALL drive out_valid equal to not-empty, and out_data equal to the head entry's lane selected by a 2-bit lane counter.
REQ-018 SHALL advance the lane counter 0->1->2->0 on each edge where out_valid and out_ready are both 1; advancing from 2 SHALL pop the head entry.
REQ-019 SHALL emit samples of a frame in order lane 0, lane 1, lane 2, and frames in arrival order.
REQ-020 SHALL support push and pop on the same edge when the FIFO is neither full nor empty, leaving the occupancy unchanged.
REQ-021 SHALL give latency of one edge: a frame accepted at edge N into an empty FIFO produces out_valid=1 after edge N, with lane 0 on out_data.
REQ-022 SHALL hold out_data and the lane counter stable while out_valid is 1 and out_ready is 0.
REQ-023 SHALL wrap FIFO read and write pointers modulo DEPTH, and SHALL track full/empty with an occupancy count of range 0..DEPTH.

Reset
REQ-024 SHALL, while rst is 0, clear pointers, occupancy, lane counter, and sat_flag, and drive out_valid=0, in_ready=0, out_data=0.
REQ-025 SHALL, on reset assertion mid-frame, discard all buffered and partially emitted frames; after release in_ready=1 on the first edge.

Configuration
REQ-026 SHALL, with OUTPUT_SERIALIZER_SAT_EN defined, clamp each shifted result to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat_flag on the accept edge of any clamped lane.
REQ-027 SHALL, with OUTPUT_SERIALIZER_SAT_EN undefined, keep the low OUT_W bits of the shifted result (wrap) and tie sat_flag to 0.

Structure
REQ-028 SHALL take IN_W, OUT_W, and the lane count L=3 defaults, plus a frame typedef (array of 3 OUT_W signed samples), from the shared package filter_pkg.
REQ-029 SHALL instantiate one sub-module, frame_fifo: a synchronous FIFO parameterized on entry type and DEPTH, with push, pop, full, empty, and head outputs.
REQ-030 SHALL keep the requantizer as combinational logic inside output_serializer.

Verification
REQ-031 Bench SHALL check rounding: lanes {2^31, 3*2^30, -2^31} -> out_data 1, 2, -1 in order.
REQ-032 Bench SHALL check saturation with SAT_EN: lanes {2^63-1, -2^63, 0} -> 0x7FFFFFFF, 0x80000000, 0, and sat_flag=1 after the accept edge; without SAT_EN, sat_flag stays 0.
REQ-033 Bench SHALL check full: out_ready=0 with 4 frames pushed -> in_ready=0; a 5th in_valid is ignored; draining yields exactly 12 samples in order.
REQ-034 Bench SHALL check streaming: in_valid=1 every cycle with out_ready=1 -> in_ready pattern steady-state 1-in-3 accept, no sample lost or duplicated.
REQ-035 Bench SHALL check backpressure: out_ready toggled every cycle -> out_data held while stalled, sequence matches the golden model.
REQ-036 Bench SHALL check reset mid-frame: rst=0 after lane 1 emitted -> out_valid=0 immediately; after release, empty and lane 0 of the next frame first.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared filter-chain definitions: default lane/sample widths and the
// three-sample frame type carried from the filter into the serializer.
package filter_pkg;
    localparam int IN_W_DEF  = 64;
    localparam int OUT_W_DEF = 32;
    localparam int L         = 3;

    // One filter frame after requantization; element 0 is the oldest sample.
    typedef logic [L-1:0][OUT_W_DEF-1:0] frame_t;
endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of whole frames. DEPTH must be a power of two so the
// pointers wrap naturally; an occupancy count separates full from empty.
module frame_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    T              mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/output_serializer.sv
// Requantizes a 3-lane filter frame, buffers whole frames, and emits them
// one sample per handshake, lane 0 first.
// Optional saturation: define OUTPUT_SERIALIZER_SAT_EN to clamp out-of-range
// samples and report them on the sticky sat_flag; otherwise results wrap.
module output_serializer
    import filter_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 31,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  y_out,
    input  logic signed [IN_W-1:0]  y_out1,
    input  logic signed [IN_W-1:0]  y_out2,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag
);
    // Half an output LSB, added before the shift for round-half-up.
    localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

    // Round and shift one lane, one bit wider than the input so the
    // rounding add cannot overflow.
    function automatic logic signed [IN_W:0] scale(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        ext = {x[IN_W-1], x};
        return (ext + $signed(RND)) >>> SHIFT;
    endfunction

    // True when the scaled value does not fit in OUT_W signed bits.
    function automatic logic ovf(input logic signed [IN_W:0] w);
        return !((&w[IN_W:OUT_W-1]) || !(|w[IN_W:OUT_W-1]));
    endfunction

    // Narrow a scaled value to the output width (clamp or wrap).
    function automatic logic [OUT_W-1:0] narrow(input logic signed [IN_W:0] w);
`ifdef OUTPUT_SERIALIZER_SAT_EN
        if (ovf(w))
            return w[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
        return w[OUT_W-1:0];
    endfunction

    logic [L-1:0][IN_W-1:0] y_lanes;
    frame_t                 wr_frame;
    frame_t                 head;
    logic                   full;
    logic                   empty;
    logic                   accept;
    logic                   fire;
    logic                   pop;
    logic [1:0]             lane;

    assign y_lanes   = {y_out2, y_out1, y_out};
    assign in_ready  = rst && !full;
    assign out_valid = rst && !empty;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign pop       = fire && (lane == 2'd2);

    // Requantize all three lanes ahead of the FIFO write.
    always_comb begin
        wr_frame = '0;
        for (int i = 0; i < L; i++)
            wr_frame[i] = narrow(scale($signed(y_lanes[i])));
    end

    frame_fifo #(
        .T     (frame_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (wr_frame),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Lane counter walks 0->1->2 across the head frame; wrapping pops it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lane <= 2'd0;
        else if (fire)
            lane <= (lane == 2'd2) ? 2'd0 : lane + 2'd1;
    end

    // Select the current lane of the head frame; zero when nothing is valid.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (lane)
                2'd0:    out_data = head[0];
                2'd1:    out_data = head[1];
                2'd2:    out_data = head[2];
                default: out_data = '0;
            endcase
        end
    end

`ifdef OUTPUT_SERIALIZER_SAT_EN
    logic [L-1:0] lane_sat;

    // Per-lane range check on the frame being offered.
    always_comb begin
        lane_sat = '0;
        for (int i = 0; i < L; i++)
            lane_sat[i] = ovf(scale($signed(y_lanes[i])));
    end

    // Sticky flag, set when a clamped frame is actually accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_flag <= 1'b0;
        else if (accept && (|lane_sat))
            sat_flag <= 1'b1;
    end
`else
    assign sat_flag = 1'b0;
`endif
endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: table of single-frame vectors plus
// hand-written full, streaming, backpressure and mid-frame reset sequences.
module tb_output_serializer;
`ifdef OUTPUT_SERIALIZER_SAT_EN
    localparam bit SAT_EXP = 1'b1;
`else
    localparam bit SAT_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [63:0] y0, y1, y2;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;

    output_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .y_out     (y0),
        .y_out1    (y1),
        .y_out2    (y2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [63:0] l [3];
        logic [31:0] e [3];
        logic        sat;
    } vec_t;

    vec_t tbl [6];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_q [$];
    int   cur_base = 0;
    int   n_out = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lane value v scaled so the requantized result is exactly v.
    function automatic logic [63:0] mk(input int v);
        longint t;
        t = longint'(v) * 64'sd2147483648;
        return t;
    endfunction

    task automatic set_frame(input int base);
        cur_base = base;
        y0 = mk(base);
        y1 = mk(base + 1);
        y2 = mk(base + 2);
    endtask

    // One clock with scoreboard bookkeeping: record accepts, check every
    // emitted sample, and check that a stalled sample is held.
    task automatic tick(output logic acc);
        #1;
        acc = in_valid && in_ready;
        if (acc)
            for (int k = 0; k < 3; k++) exp_q.push_back(cur_base + k);
        if (prev_stall) chk("hold_data", out_data, prev_data);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("sb_extra_sample", 32'd1, 32'd0);
            else                   chk("sb_data", out_data, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   n_acc;
        int   cyc;

        tbl[0].nm = "round";   tbl[0].l = '{64'h80000000, 64'hC0000000, 64'hFFFFFFFF80000000};
        tbl[0].e = '{32'd1, 32'd2, 32'hFFFFFFFF}; tbl[0].sat = 1'b0;
        tbl[1].nm = "round_pos"; tbl[1].l = '{64'h3FFFFFFF, 64'h40000000, 64'h7FFFFFFF};
        tbl[1].e = '{32'd0, 32'd1, 32'd1}; tbl[1].sat = 1'b0;
        tbl[2].nm = "round_neg"; tbl[2].l = '{64'hFFFFFFFFC0000000, 64'hFFFFFFFFBFFFFFFF, 64'hFFFFFFFF40000000};
        tbl[2].e = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}; tbl[2].sat = 1'b0;
        tbl[3].nm = "ints";    tbl[3].l = '{mk(5), mk(-7), mk(1000)};
        tbl[3].e = '{32'd5, 32'hFFFFFFF9, 32'd1000}; tbl[3].sat = 1'b0;
        tbl[4].nm = "extreme"; tbl[4].l = '{64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h0};
        if (SAT_EXP) tbl[4].e = '{32'h7FFFFFFF, 32'h80000000, 32'h0};
        else         tbl[4].e = '{32'h0, 32'h0, 32'h0};
        tbl[4].sat = SAT_EXP;
        tbl[5].nm = "after_sat"; tbl[5].l = '{mk(0), mk(1), mk(2)};
        tbl[5].e = '{32'd0, 32'd1, 32'd2}; tbl[5].sat = SAT_EXP;

        // Reset state
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; y0 = '0; y1 = '0; y2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_sat_flag",  32'(sat_flag),  32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rel_in_ready",  32'(in_ready),  32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Table-driven single-frame vectors, out_ready held high
        out_ready = 1'b1;
        foreach (tbl[v]) begin
            y0 = tbl[v].l[0]; y1 = tbl[v].l[1]; y2 = tbl[v].l[2];
            in_valid = 1'b1;
            #1 chk({tbl[v].nm, "_in_ready"}, 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tbl[v].nm, "_sat_flag"}, 32'(sat_flag), 32'(tbl[v].sat));
            for (int k = 0; k < 3; k++) begin
                #1;
                chk({tbl[v].nm, "_valid"}, 32'(out_valid), 32'd1);
                chk({tbl[v].nm, "_data"}, out_data, tbl[v].e[k]);
                @(posedge clk); #1;
            end
            chk({tbl[v].nm, "_drained"}, 32'(out_valid), 32'd0);
        end

        // Full: four frames with no consumer, fifth offer ignored
        out_ready = 1'b0; n_out = 0; prev_stall = 1'b0;
        for (int f = 0; f < 4; f++) begin
            set_frame(3000 + 3 * f);
            in_valid = 1'b1;
            tick(acc);
            chk("full_fill_accept", 32'(acc), 32'd1);
        end
        #1 chk("full_in_ready", 32'(in_ready), 32'd0);
        set_frame(9000);
        tick(acc);
        chk("full_fifth_ignored", 32'(acc), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 20) begin tick(acc); cyc++; end
        chk("full_drain_count", 32'(n_out), 32'd12);
        chk("full_drain_left",  32'(exp_q.size()), 32'd0);
        chk("full_drain_empty", 32'(out_valid), 32'd0);

        // Streaming: continuous offers with a free consumer
        n_out = 0; n_acc = 0; out_ready = 1'b1;
        set_frame(4000);
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(acc);
            if (acc) begin
                if (c >= 18) n_acc++;
                set_frame(cur_base + 3);
            end
        end
        chk("stream_accept_rate", 32'(n_acc), 32'd4);
        in_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin tick(acc); cyc++; end
        chk("stream_drain_left", 32'(exp_q.size()), 32'd0);
        chk("stream_no_extra",   32'(out_valid), 32'd0);
        chk("stream_samples",    32'(n_out), 32'(cur_base - 4000));

        // Backpressure: out_ready toggles every cycle
        out_ready = 1'b0; n_out = 0;
        for (int f = 0; f < 3; f++) begin
            set_frame(2000 + 3 * f);
            in_valid = 1'b1;
            tick(acc);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = c[0];
            tick(acc);
        end
        chk("bp_samples",    32'(n_out), 32'd9);
        chk("bp_drain_left", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame after lane 1 has been emitted
        out_ready = 1'b1;
        set_frame(5000);
        in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_out_data",  out_data,       32'd0);
        chk("mid_rst_sat_flag",  32'(sat_flag),  32'd0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rel_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rel_out_valid", 32'(out_valid), 32'd0);
        set_frame(6000);
        in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        chk("mid_next_valid", 32'(out_valid), 32'd1);
        chk("mid_next_lane0", out_data, 32'd6000);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 10) begin tick(acc); cyc++; end
        chk("mid_drain_left", 32'(exp_q.size()), 32'd0);
        chk("mid_empty",      32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
